// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting in front of the decoder. It owns the
// program counter and fetches one word at a time from instruction memory
// over a req/valid handshake. Memory latency may vary, and the memory may
// answer in the same cycle as the request. The fetched instruction is held
// on inst/inst_valid until the decoder accepts it. On accept the PC moves
// to pc+4, or to the branch target when branchEn is set. A flush can
// redirect the PC in any state.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   stall                decoder not ready, so the held instruction stays
//   branchEn             on accept, take branchTarget instead of pc+4
//   branchTarget         branch/jump target (low two bits are cleared)
//   flush, flushPc       redirect request and address; beats branchEn
//   imem_req, imem_addr  fetch request and word-aligned address (= pc)
//   imem_rdata           returned instruction word
//   imem_valid           imem_rdata is valid this cycle
//   inst, inst_valid     instruction presented to the decoder
//   pc, pcPlus4          address of current request/held instruction, +4
//   misalign_err         one-cycle pulse: a misaligned target was taken
//   fetch_timeout        sticky flag: a request waited too long
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd64,
  parameter logic [31:0] NOP_INST       = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branchEn,
  input  logic [31:0] branchTarget,
  input  logic        flush,
  input  logic [31:0] flushPc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        misalign_err,
  output logic        fetch_timeout
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  logic [31:0] redirect_reg;   // flush target waiting for the in-flight word
  logic        req_reg;
  logic        valid_reg;
  logic        drop_reg;       // the in-flight word belongs to a flushed path
  logic        mis_reg;
  logic        timeout_reg;
  logic [15:0] wdog_reg;

  logic [31:0] flush_aligned;
  logic [31:0] branch_aligned;
  logic [31:0] pc_plus4;
  logic        flush_misaligned;
  logic        branch_misaligned;
  logic [15:0] wdog_next;
  logic        wdog_hit;

  assign flush_aligned     = {flushPc[31:2], 2'b00};
  assign branch_aligned    = {branchTarget[31:2], 2'b00};
  assign flush_misaligned  = |flushPc[1:0];
  assign branch_misaligned = |branchTarget[1:0];
  assign pc_plus4          = pc_reg + 32'd4;

  // The counter saturates so that a very long wait cannot wrap it back to
  // zero. The flag is sticky in any case.
  assign wdog_next = (wdog_reg == 16'hFFFF) ? wdog_reg : wdog_reg + 16'd1;
  assign wdog_hit  = (TIMEOUT_CYCLES != 16'd0) && (wdog_next == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_RESET;
      pc_reg       <= RESET_PC;
      inst_reg     <= NOP_INST;
      redirect_reg <= RESET_PC;
      req_reg      <= 1'b0;
      valid_reg    <= 1'b0;
      drop_reg     <= 1'b0;
      mis_reg      <= 1'b0;
      timeout_reg  <= 1'b0;
      wdog_reg     <= 16'd0;
    end else begin
      // misalign_err is a single-cycle pulse. Any branch below that takes a
      // misaligned target raises it again.
      mis_reg <= 1'b0;

      case (state_reg)
        S_RESET: begin
          state_reg <= S_REQ;
          req_reg   <= 1'b1;
          wdog_reg  <= 16'd0;
          if (flush) begin
            pc_reg  <= flush_aligned;
            mis_reg <= flush_misaligned;
          end
        end

        S_REQ: begin
          if (imem_valid) begin
            wdog_reg <= 16'd0;
            drop_reg <= 1'b0;
            if (flush) begin
              // Returning data belongs to the abandoned path. Refetch from
              // the new target, and stay in S_REQ.
              pc_reg  <= flush_aligned;
              mis_reg <= flush_misaligned;
            end else if (drop_reg) begin
              // This is the late answer to a flushed request. Throw it away
              // and start the redirected fetch.
              pc_reg <= redirect_reg;
            end else begin
              inst_reg  <= imem_rdata;
              valid_reg <= 1'b1;
              req_reg   <= 1'b0;
              state_reg <= S_HOLD;
            end
          end else begin
            wdog_reg <= wdog_next;
            if (wdog_hit) begin
              timeout_reg <= 1'b1;
            end
            if (flush) begin
              // The bus request must stay stable until it completes, so
              // only record where to go afterwards.
              redirect_reg <= flush_aligned;
              drop_reg     <= 1'b1;
              mis_reg      <= flush_misaligned;
            end
          end
        end

        S_HOLD: begin
          wdog_reg <= 16'd0;
          if (flush) begin
            pc_reg    <= flush_aligned;
            mis_reg   <= flush_misaligned;
            inst_reg  <= NOP_INST;
            valid_reg <= 1'b0;
            req_reg   <= 1'b1;
            state_reg <= S_REQ;
          end else if (!stall) begin
            pc_reg    <= branchEn ? branch_aligned : pc_plus4;
            mis_reg   <= branchEn & branch_misaligned;
            inst_reg  <= NOP_INST;
            valid_reg <= 1'b0;
            req_reg   <= 1'b1;
            state_reg <= S_REQ;
          end
        end

        default: begin
          state_reg <= S_RESET;
          req_reg   <= 1'b0;
          valid_reg <= 1'b0;
          inst_reg  <= NOP_INST;
        end
      endcase
    end
  end

  assign imem_req      = req_reg;
  assign imem_addr     = pc_reg;
  assign inst          = inst_reg;
  assign inst_valid    = valid_reg;
  assign pc            = pc_reg;
  assign pcPlus4       = pc_plus4;
  assign misalign_err  = mis_reg;
  assign fetch_timeout = timeout_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Drives fetch_unit against a behavioural instruction memory. The memory
// returns a fixed function of the address, with a configurable random
// latency, or its handshake can be driven by hand.
//
// The bench runs four kinds of checks:
//   - directed boot and stall sequences;
//   - a table of accept/branch/flush vectors;
//   - hand-written flush-during-request and watchdog sequences;
//   - a randomized run checked against an architectural model. The model
//     tracks which address the next presented instruction must come from.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall;
  logic        branchEn;
  logic [31:0] branchTarget;
  logic        flush;
  logic [31:0] flushPc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        misalign_err;
  logic        fetch_timeout;

  // The memory response comes either from the automatic model or from
  // values driven by hand.
  logic        auto_mem;
  int unsigned lat_max;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        man_valid;
  logic [31:0] man_rdata;

  assign imem_valid = auto_mem ? mem_valid : man_valid;
  assign imem_rdata = auto_mem ? mem_rdata : man_rdata;

  int total = 0;
  int bad   = 0;
  int addr_err = 0;
  int npres = 0;

  fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(16'd4),
    .NOP_INST      (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branchEn     (branchEn),
    .branchTarget (branchTarget),
    .flush        (flush),
    .flushPc      (flushPc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .pc           (pc),
    .pcPlus4      (pcPlus4),
    .misalign_err (misalign_err),
    .fetch_timeout(fetch_timeout)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Automatic memory model. It acts just after the falling edge, so its
  // answer is stable well before the next rising edge. It also flags any
  // change of imem_addr while a request is still outstanding.
  logic        m_out = 1'b0;
  int          m_lat = 0;
  logic [31:0] m_addr = 32'h0;

  initial begin
    mem_valid = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (rst || !auto_mem) begin
        m_out     = 1'b0;
        mem_valid = 1'b0;
      end else if (imem_req) begin
        if (!m_out) begin
          m_out  = 1'b1;
          m_lat  = int'($urandom_range(lat_max, 0));
          m_addr = imem_addr;
        end else if (imem_addr !== m_addr) begin
          addr_err++;
        end
        if (m_lat == 0) begin
          mem_valid = 1'b1;
          mem_rdata = mem_word(m_addr);
          m_out     = 1'b0;
        end else begin
          mem_valid = 1'b0;
          m_lat--;
        end
      end else begin
        mem_valid = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "simulation time limit exceeded");
  end

  // Redirect to 'start' with the decoder stalled. Then wait, within a
  // bound, until the instruction at that address is presented.
  task automatic go_hold(input logic [31:0] start);
    int n;
    stall    = 1'b1;
    branchEn = 1'b0;
    flush    = 1'b1;
    flushPc  = start;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    while (!inst_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1("hold_reached", inst_valid, 1'b1);
    check("hold_pc", pc, start);
    check("hold_inst", inst, mem_word(start));
    check("hold_pcplus4", pcPlus4, start + 32'd4);
  endtask

  typedef struct {
    logic [31:0] start;
    logic        br;
    logic [31:0] bt;
    logic        fl;
    logic [31:0] fp;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[7];

  // Variables used by the random phase.
  logic        r_held;
  logic        r_stay;
  logic        r_mis;
  logic [31:0] r_old_inst;
  logic [31:0] r_old_pc;
  logic [31:0] exp_pc;

  initial begin
    vecs[0] = '{32'h0000_0010, 1'b1, 32'h0000_0040, 1'b0, 32'h0,         32'h0000_0040, 1'b0};
    vecs[1] = '{32'h0000_0010, 1'b1, 32'h0000_0042, 1'b0, 32'h0,         32'h0000_0040, 1'b1};
    vecs[2] = '{32'h0000_0010, 1'b0, 32'h0000_0099, 1'b0, 32'h0,         32'h0000_0014, 1'b0};
    vecs[3] = '{32'h0000_0010, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080, 32'h0000_0080, 1'b0};
    vecs[4] = '{32'h0000_0020, 1'b0, 32'h0,         1'b1, 32'h0000_0103, 32'h0000_0100, 1'b1};
    vecs[5] = '{32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0000, 1'b0};
    vecs[6] = '{32'h0000_0050, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b1};

    rst          = 1'b1;
    stall        = 1'b0;
    branchEn     = 1'b0;
    branchTarget = 32'h0;
    flush        = 1'b0;
    flushPc      = 32'h0;
    auto_mem     = 1'b1;
    lat_max      = 0;
    man_valid    = 1'b0;
    man_rdata    = 32'h0;

    // ---- reset and boot ----
    @(negedge clk);
    @(negedge clk);
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, NOP);
    check("rst_pc", pc, 32'h0);
    check1("rst_mis", misalign_err, 1'b0);
    check1("rst_timeout", fetch_timeout, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check1("boot_req", imem_req, 1'b1);
    check("boot_addr", imem_addr, 32'h0);
    check1("boot_novalid", inst_valid, 1'b0);
    @(negedge clk);
    check("boot_inst", inst, 32'h0050_0093);
    check1("boot_valid", inst_valid, 1'b1);
    check("boot_pc", pc, 32'h0);
    check("boot_pcplus4", pcPlus4, 32'h4);
    check1("boot_req_low", imem_req, 1'b0);
    $display("boot: pc=%h inst=%h", pc, inst);

    // ---- stall for five cycles ----
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_inst", inst, 32'h0050_0093);
      check("stall_pc", pc, 32'h0);
      check1("stall_req", imem_req, 1'b0);
      check1("stall_valid", inst_valid, 1'b1);
    end
    stall = 1'b0;
    @(negedge clk);
    check1("seq_req4", imem_req, 1'b1);
    check("seq_addr4", imem_addr, 32'h4);
    @(negedge clk);
    check("seq_inst4", inst, mem_word(32'h4));
    check1("seq_valid4", inst_valid, 1'b1);
    @(negedge clk);
    check("seq_addr8", imem_addr, 32'h8);
    stall = 1'b1;
    $display("stall sequence: next address %h", imem_addr);

    // ---- accept / branch / flush table ----
    for (int i = 0; i < 7; i++) begin
      go_hold(vecs[i].start);
      stall        = 1'b0;
      branchEn     = vecs[i].br;
      branchTarget = vecs[i].bt;
      flush        = vecs[i].fl;
      flushPc      = vecs[i].fp;
      @(negedge clk);
      stall    = 1'b1;
      branchEn = 1'b0;
      flush    = 1'b0;
      check("vec_addr", imem_addr, vecs[i].exp_addr);
      check1("vec_mis", misalign_err, vecs[i].exp_mis);
      check1("vec_valid", inst_valid, 1'b0);
      check1("vec_req", imem_req, 1'b1);
      $display("vec %0d: start=%h br=%b bt=%h fl=%b fp=%h -> addr=%h mis=%b",
               i, vecs[i].start, vecs[i].br, vecs[i].bt, vecs[i].fl, vecs[i].fp,
               imem_addr, misalign_err);
      @(negedge clk);
      check1("vec_mis_pulse", misalign_err, 1'b0);
    end

    // ---- flush while a request waits on memory ----
    go_hold(32'h300);
    auto_mem  = 1'b0;
    man_valid = 1'b0;
    stall     = 1'b0;
    @(negedge clk);
    check1("fmr_req", imem_req, 1'b1);
    check("fmr_addr0", imem_addr, 32'h304);
    @(negedge clk);
    check("fmr_addr1", imem_addr, 32'h304);
    flush   = 1'b1;
    flushPc = 32'h200;
    @(negedge clk);
    flush = 1'b0;
    check("fmr_addr2", imem_addr, 32'h304);
    check1("fmr_mis", misalign_err, 1'b0);
    @(negedge clk);
    check("fmr_addr3", imem_addr, 32'h304);
    man_valid = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    man_valid = 1'b0;
    check1("fmr_dropped", inst_valid, 1'b0);
    check1("fmr_req_again", imem_req, 1'b1);
    check("fmr_redirect", imem_addr, 32'h200);
    stall     = 1'b1;
    man_valid = 1'b1;
    man_rdata = mem_word(32'h200);
    @(negedge clk);
    man_valid = 1'b0;
    check1("fmr_valid", inst_valid, 1'b1);
    check("fmr_pc", pc, 32'h200);
    check("fmr_inst", inst, mem_word(32'h200));
    $display("flush mid-request: presented pc=%h inst=%h", pc, inst);
    auto_mem = 1'b1;

    // ---- randomized run against the architectural model ----
    lat_max = 3;
    go_hold(32'h1000);
    exp_pc = 32'h1000;
    for (int n = 0; n < 1500; n++) begin
      stall        = ($urandom_range(2, 0) == 0);
      flush        = ($urandom_range(11, 0) == 0);
      flushPc      = $urandom_range(32'h3FFF, 0);
      branchEn     = ($urandom_range(1, 0) == 1);
      branchTarget = $urandom_range(32'h3FFF, 0);

      r_held     = inst_valid;
      r_old_inst = inst;
      r_old_pc   = pc;
      r_stay     = r_held && stall && !flush;
      r_mis      = (flush && (flushPc[1:0] != 2'b00)) ||
                   (r_held && !stall && !flush && branchEn && (branchTarget[1:0] != 2'b00));
      if (flush)
        exp_pc = {flushPc[31:2], 2'b00};
      else if (r_held && !stall)
        exp_pc = branchEn ? {branchTarget[31:2], 2'b00} : exp_pc + 32'd4;

      @(negedge clk);
      check1("rnd_mis", misalign_err, r_mis);
      check1("rnd_req", imem_req, !inst_valid);
      check1("rnd_timeout", fetch_timeout, 1'b0);
      if (r_stay) begin
        check1("rnd_hold_valid", inst_valid, 1'b1);
        check("rnd_hold_inst", inst, r_old_inst);
        check("rnd_hold_pc", pc, r_old_pc);
      end else if (r_held || flush) begin
        check1("rnd_left_hold", inst_valid, 1'b0);
      end else if (inst_valid) begin
        npres++;
        check("rnd_pc", pc, exp_pc);
        check("rnd_inst", inst, mem_word(exp_pc));
        check("rnd_pcplus4", pcPlus4, exp_pc + 32'd4);
        $display("present %0d: pc=%h inst=%h", npres, pc, inst);
      end
    end
    flush    = 1'b0;
    branchEn = 1'b0;
    check1("rnd_progress", (npres > 100), 1'b1);
    check("addr_stable", addr_err, 32'd0);

    // ---- watchdog ----
    lat_max = 0;
    go_hold(32'h400);
    auto_mem  = 1'b0;
    man_valid = 1'b0;
    stall     = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check1("wd_not_yet", fetch_timeout, 1'b0);
      @(negedge clk);
    end
    check1("wd_set", fetch_timeout, 1'b1);
    check1("wd_still_req", imem_req, 1'b1);
    check("wd_addr", imem_addr, 32'h404);
    @(negedge clk);
    @(negedge clk);
    check1("wd_sticky_wait", fetch_timeout, 1'b1);
    man_valid = 1'b1;
    man_rdata = mem_word(32'h404);
    @(negedge clk);
    man_valid = 1'b0;
    check1("wd_valid_late", inst_valid, 1'b1);
    check("wd_inst", inst, mem_word(32'h404));
    @(negedge clk);
    check1("wd_sticky_after", fetch_timeout, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check1("wd_cleared", fetch_timeout, 1'b0);
    check1("wd_rst_valid", inst_valid, 1'b0);
    $display("watchdog: flag cleared by reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the decode/control unit. Holds the program counter and issues word requests to instruction memory over a req/valid handshake with variable latency. Presents one instruction at a time on inst/inst_valid to the decoder and holds it while the pipeline stalls. Advances the PC by 4 or to the branch target on accept, and supports an asynchronous-to-pipeline flush/redirect.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
TIMEOUT_CYCLES, 16'd64, cycles a request may wait for imem_valid before fetch_timeout sets; 0 disables the watchdog
NOP_INST, 32'h0000_0013, value driven on inst when no valid instruction is held (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
stall  input  1  decoder/pipeline not ready; held instruction must not advance
branchEn  input  1  from control; on accept, next PC = branchTarget instead of pc+4
branchTarget  input  32  computed branch/jump target
flush  input  1  redirect request, any state, priority over branchEn
flushPc  input  32  redirect address
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  word-aligned fetch address
imem_rdata  input  32  returned instruction word
imem_valid  input  1  imem_rdata valid; may assert in the same cycle as imem_req
inst  output  32  instruction to decoder
inst_valid  output  1  inst holds a fetched instruction
pc  output  32  address of the current request / held instruction
pcPlus4  output  32  pc + 4, for link-register writeback
misalign_err  output  1  one-cycle pulse: a target with [1:0] != 0 was taken
fetch_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (rst high at clock edge): pc=RESET_PC, state=S_RESET, imem_req=0, inst=NOP_INST, inst_valid=0, misalign_err=0, fetch_timeout=0, drop flag=0, watchdog=0. rst mid-transaction abandons the outstanding request; a late imem_valid after reset is ignored until S_REQ is reentered.
- States:
  - S_RESET: one cycle after rst deasserts, then S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc. Address stays stable until imem_valid.
  - S_HOLD: imem_req=0, inst_valid=1, inst stable.
- S_REQ on imem_valid with drop=0 and flush=0: latch inst=imem_rdata, inst_valid=1, go S_HOLD.
- Latency: with combinational memory (valid same cycle as req), an instruction is presented 1 cycle after S_REQ is entered. Maximum throughput is one instruction per 2 cycles.
- Accept = S_HOLD && !stall && !flush. On accept:
  - pc <= branchEn ? {branchTarget[31:2],2'b00} : pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
  - inst_valid <= 0, inst <= NOP_INST, go S_REQ.
- branchEn and branchTarget are sampled only on the accept cycle and ignored otherwise.
- S_HOLD with stall=1: all outputs hold indefinitely.
- Flush in S_HOLD: drop inst (inst_valid=0, inst=NOP_INST), pc <= aligned flushPc, go S_REQ.
- Flush in S_REQ without imem_valid in the same cycle:
  - the pending request stays on the bus unchanged;
  - record aligned flushPc as the redirect target and set drop=1;
  - when imem_valid arrives, discard the data, clear drop, pc <= redirect target, remain S_REQ (new address from the next cycle).
- Flush in S_REQ in the same cycle as imem_valid: discard the data, pc <= aligned flushPc, remain S_REQ.
- A later flush while drop=1 overwrites the redirect target.
- Flush and branchEn in the same cycle: flush wins.
- Alignment: taken target (branch or flush) with [1:0] != 0 → low bits cleared, misalign_err=1 for exactly the next cycle.
- Watchdog:
  - 16-bit counter increments each S_REQ cycle without imem_valid, clears on imem_valid or on leaving S_REQ.
  - When it reaches TIMEOUT_CYCLES (nonzero), fetch_timeout=1 until rst. The fetch keeps waiting.
- pcPlus4 = pc + 4 combinationally.
- Outputs are registered except imem_addr (= pc) and pcPlus4.

Test Plan:
- Reset/boot: rst 2 cycles, memory returns 32'h00500093 with 0-latency valid → cycle after rst low: imem_req=1, imem_addr=0; next cycle inst=32'h00500093, inst_valid=1, pc=0, pcPlus4=4.
- Sequential with stall: stall=1 for 5 cycles in S_HOLD → inst/pc unchanged and imem_req=0 throughout; stall low → next imem_addr=4, then 8.
- Branch: held inst at pc=0x10, branchEn=1, branchTarget=0x40 on accept → imem_addr=0x40. branchTarget=0x42 → imem_addr=0x40 and misalign_err pulses 1 cycle.
- Flush mid-request: memory latency 3, flush=1 with flushPc=0x200 on the 2nd wait cycle → imem_addr stays at the old address until valid, that data is never presented, next request imem_addr=0x200.
- Flush vs branch: in S_HOLD with stall=0, branchEn=1 to 0x40 and flush to 0x80 in the same cycle → next imem_addr=0x80.
- Watchdog: TIMEOUT_CYCLES=4, imem_valid never asserts → fetch_timeout=1 after 4 waiting cycles and stays set after valid later arrives; clears only on rst.
